// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - EX-stage multiply/divide sequencer owning HI/LO
// Results are computed at start, held in pending registers, and committed when the busy count expires.
module md_scheduler #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  EX_MdOp,
   input  logic [31:0] EX_A,
   input  logic [31:0] EX_B,
   input  logic        ID_MdUse,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0]  counter;
   logic [31:0] pending_hi;
   logic [31:0] pending_lo;
   logic        pending_write;

   logic        is_start;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic [31:0] num;
   logic [31:0] den;
   logic [31:0] den_safe;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quot;
   logic [31:0] rem;

   assign is_start = (EX_MdOp == OP_MULT) || (EX_MdOp == OP_MULTU) ||
                     (EX_MdOp == OP_DIV)  || (EX_MdOp == OP_DIVU);

   // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
   assign prod_s = {{32{EX_A[31]}}, EX_A} * {{32{EX_B[31]}}, EX_B};
   assign prod_u = {32'd0, EX_A} * {32'd0, EX_B};

   // Signed divide works on magnitudes; -0x80000000 stays 0x80000000, which is 2^31 unsigned.
   always_comb begin
      div_signed = (EX_MdOp == OP_DIV);
      num        = (div_signed && EX_A[31]) ? -EX_A : EX_A;
      den        = (div_signed && EX_B[31]) ? -EX_B : EX_B;
      den_safe   = (den == 32'd0) ? 32'd1 : den;
      uq         = num / den_safe;
      ur         = num % den_safe;
      quot       = (div_signed && (EX_A[31] ^ EX_B[31])) ? -uq : uq;
      rem        = (div_signed && EX_A[31]) ? -ur : ur;
   end

   assign busy     = (counter != 4'd0);
   assign md_stall = ID_MdUse & (is_start | busy);

   always_ff @(posedge clk) begin
      if (reset) begin
         counter       <= 4'd0;
         pending_hi    <= 32'd0;
         pending_lo    <= 32'd0;
         pending_write <= 1'b0;
         HI            <= 32'd0;
         LO            <= 32'd0;
      end else if (counter != 4'd0) begin
         counter <= counter - 4'd1;
         if (counter == 4'd1 && pending_write) begin
            HI <= pending_hi;
            LO <= pending_lo;
         end
      end else begin
         case (EX_MdOp)
            OP_MULT: begin
               counter       <= MULT_LOAD;
               pending_hi    <= prod_s[63:32];
               pending_lo    <= prod_s[31:0];
               pending_write <= 1'b1;
            end
            OP_MULTU: begin
               counter       <= MULT_LOAD;
               pending_hi    <= prod_u[63:32];
               pending_lo    <= prod_u[31:0];
               pending_write <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               counter       <= DIV_LOAD;
               pending_hi    <= rem;
               pending_lo    <= quot;
               pending_write <= (EX_B != 32'd0);
            end
            OP_MTHI: HI <= EX_A;
            OP_MTLO: LO <= EX_A;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - randomized and directed bench for md_scheduler with a reference model
module tb_md_scheduler;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  EX_MdOp;
   logic [31:0] EX_A;
   logic [31:0] EX_B;
   logic        ID_MdUse;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .EX_MdOp(EX_MdOp), .EX_A(EX_A), .EX_B(EX_B),
      .ID_MdUse(ID_MdUse), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic in 64-bit integers, straight from the MIPS definitions.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
         3'd2: begin p = 64'(a) * 64'(b); exp_hi = p[63:32]; exp_lo = p[31:0]; end
         3'd3: if (b != 0) begin
                  q = sa / sb; r = sa % sb;
                  exp_lo = q[31:0]; exp_hi = r[31:0];
               end
         3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
         3'd5: exp_hi = a;
         3'd6: exp_lo = a;
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] old_hi, old_lo;
      int n;
      n = (op <= 3'd2) ? MC : DC;
      old_hi = exp_hi;
      old_lo = exp_lo;
      EX_MdOp = op; EX_A = a; EX_B = b; ID_MdUse = 1'b1;
      #1;
      check("start_stall", {31'd0, md_stall}, 32'd1);
      check("start_idle", {31'd0, busy}, 32'd0);
      model(op, a, b);
      step();
      EX_MdOp = 3'd0;
      for (int i = 1; i <= n; i++) begin
         ID_MdUse = (i != 3);
         #1;
         check("busy_on", {31'd0, busy}, 32'd1);
         check("busy_stall", {31'd0, md_stall}, (i != 3) ? 32'd1 : 32'd0);
         check("hold_hi", HI, old_hi);
         check("hold_lo", LO, old_lo);
         EX_MdOp = (i == 2) ? 3'd5 : ((i == 4) ? 3'd2 : 3'd0);
         EX_A = 32'hABCD;
         step();
         EX_MdOp = 3'd0;
      end
      ID_MdUse = 1'b1;
      #1;
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_stall", {31'd0, md_stall}, 32'd0);
      check("result_hi", HI, exp_hi);
      check("result_lo", LO, exp_lo);
   endtask

   task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
      EX_MdOp = op; EX_A = a; ID_MdUse = 1'b1;
      #1;
      check("mt_stall", {31'd0, md_stall}, 32'd0);
      model(op, a, 32'd0);
      step();
      EX_MdOp = 3'd0;
      check("mt_busy", {31'd0, busy}, 32'd0);
      check("mt_hi", HI, exp_hi);
      check("mt_lo", LO, exp_lo);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b1; EX_MdOp = 3'd0; EX_A = 32'd0; EX_B = 32'd0; ID_MdUse = 1'b1;
      step(); step();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_stall", {31'd0, md_stall}, 32'd0);
      reset = 1'b0;

      // Reset mid-DIV: in-flight result must never land.
      run_mt(3'd5, 32'h1234);
      EX_MdOp = 3'd3; EX_A = 32'd7; EX_B = 32'd2;
      step();
      EX_MdOp = 3'd0;
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_hi", HI, 32'd0);
      check("rstmid_lo", LO, 32'd0);
      for (int i = 0; i < DC + 2; i++) step();
      check("rstmid_late_hi", HI, 32'd0);
      check("rstmid_late_lo", LO, 32'd0);
      exp_hi = 32'd0; exp_lo = 32'd0;

      run_op(3'd1, 32'd3, 32'hFFFFFFFE);
      check("mult_hi_const", HI, 32'hFFFFFFFF);
      check("mult_lo_const", LO, 32'hFFFFFFFA);
      run_op(3'd2, 32'd3, 32'hFFFFFFFE);
      check("multu_hi_const", HI, 32'h00000002);
      run_op(3'd3, 32'hFFFFFFF9, 32'd2);
      check("div_neg_lo", LO, 32'hFFFFFFFD);
      check("div_neg_hi", HI, 32'hFFFFFFFF);
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf_lo", LO, 32'h80000000);
      check("div_ovf_hi", HI, 32'h0);
      run_op(3'd4, 32'hFFFFFFFF, 32'h10);
      check("divu_lo", LO, 32'h0FFFFFFF);
      check("divu_hi", HI, 32'hF);

      run_mt(3'd5, 32'h11);
      run_mt(3'd6, 32'h22);
      run_op(3'd3, 32'd12345, 32'd0);
      check("dz_hi", HI, 32'h11);
      check("dz_lo", LO, 32'h22);
      run_op(3'd4, 32'd99, 32'd0);
      run_mt(3'd6, 32'h5);
      check("mtlo_val", LO, 32'h5);

      for (int k = 0; k < 24; k++) begin
         rop = 3'($urandom_range(1, 4));
         ra = $urandom();
         rb = $urandom();
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 16));
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) run_mt(3'($urandom_range(5, 6)), $urandom());
         run_op(rop, ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
